// File: rtl/sum_bcd_converter.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) placed
// after the parallel adder; valid/ready handshake on both the sum and BCD sides.
module sum_bcd_converter #(
  parameter int IN_W   = 5,
  parameter int DIGITS = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_W-1:0]     sum,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] bcd,
  output logic                busy
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(IN_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [BCD_W-1:0] work;
  logic [IN_W-1:0]  bin;
  logic [CNT_W-1:0] cnt;

  logic [BCD_W-1:0] adj;
  logic [BCD_W-1:0] next_work;
  logic [IN_W-1:0]  next_bin;

  // Any digit >= 5 would exceed 9 after doubling, so pre-bias it by 3.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] d);
    logic [BCD_W-1:0] r;
    r = d;
    for (int i = 0; i < DIGITS; i++) begin
      if (d[4*i +: 4] >= 4'd5) r[4*i +: 4] = d[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  always_comb begin
    adj       = add3(work);
    next_work = {adj[BCD_W-2:0], bin[IN_W-1]};
    next_bin  = {bin[IN_W-2:0], 1'b0};
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      work  <= '0;
      bin   <= '0;
      cnt   <= '0;
      bcd   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            bin   <= sum;
            work  <= '0;
            cnt   <= CNT_W'(IN_W);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          work <= next_work;
          bin  <= next_bin;
          cnt  <= cnt - CNT_W'(1);
          // Last bit shifted in: publish the finished digits in the same edge.
          if (cnt == CNT_W'(1)) begin
            bcd   <= next_work;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sum_bcd_converter.sv
// Bench for sum_bcd_converter: vector table, exhaustive sweep, random runs with
// stalls, and hand-written reset/backpressure/busy/back-to-back sequences.
module tb_sum_bcd_converter;

  localparam int IN_W   = 5;
  localparam int DIGITS = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] sum;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] bcd;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  sum_bcd_converter #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bcd       (bcd),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] s;
    logic [7:0] e;
  } vec_t;

  vec_t tbl [8];

  // Decimal digits of v, packed tens:units.
  function automatic logic [7:0] model(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic convert(input logic [4:0] v, input int stall);
    int cyc;
    cyc = 0;
    while (!in_ready && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("ready_wait", 32'(in_ready), 32'd1);
    sum       = v;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    tick();
    in_valid = 1'b0;
    sum      = 5'($urandom);
    cyc      = 0;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("latency", 32'(cyc), 32'(IN_W));
    chk("bcd", 32'(bcd), 32'(model(int'(v))));
    for (int i = 0; i < stall; i++) begin
      tick();
      chk("stall_hold", {23'd0, out_valid, in_ready, bcd}, {23'd0, 1'b1, 1'b0, model(int'(v))});
    end
    out_ready = 1'b1;
    tick();
    chk("back_idle", {30'd0, in_ready, out_valid}, 32'b10);
  endtask

  initial begin
    int c, n, r, pre_ready;
    int acc [3];
    logic [4:0] seq [3];

    tbl[0] = '{5'd9,  8'h09};
    tbl[1] = '{5'd10, 8'h10};
    tbl[2] = '{5'd19, 8'h19};
    tbl[3] = '{5'd30, 8'h30};
    tbl[4] = '{5'd31, 8'h31};
    tbl[5] = '{5'd0,  8'h00};
    tbl[6] = '{5'd5,  8'h05};
    tbl[7] = '{5'd27, 8'h27};

    rst_n = 1'b0; in_valid = 1'b0; sum = '0; out_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_state", {28'd0, in_ready, out_valid, busy, 1'b0}, {28'd0, 4'b1000});
    chk("rst_bcd", 32'(bcd), 32'h00);

    // Reset during SHIFT abandons the conversion.
    sum = 5'd25; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("shift_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_idle", {30'd0, in_ready, busy}, 32'b10);
    r = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid || bcd != 8'h00) r++;
    end
    chk("midrst_quiet", 32'(r), 32'd0);

    for (int i = 0; i < 8; i++) begin
      convert(tbl[i].s, 0);
      chk("tbl_bcd", 32'(bcd), 32'(tbl[i].e));
    end

    for (int v = 0; v < 32; v++) convert(5'(v), 0);

    for (int i = 0; i < 20; i++) convert(5'($urandom), int'($urandom_range(0, 3)));

    // Backpressure: 4 stalled cycles after out_valid rises.
    convert(5'd23, 4);

    // Busy-input rejection: sum changes to 29 and in_valid stays high.
    sum = 5'd7; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    sum = 5'd29;
    c = 0; r = 0;
    while (!out_valid && c < 20) begin
      if (in_ready) r++;
      tick();
      c++;
    end
    chk("rej_latency", 32'(c), 32'(IN_W));
    chk("rej_ready", 32'(r), 32'd0);
    chk("rej_bcd", 32'(bcd), 32'h07);
    tick();
    chk("rej_idle", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    c = 0;
    while (!out_valid && c < 20) begin
      tick();
      c++;
    end
    chk("rej_second", 32'(bcd), 32'h29);
    tick();

    // Back-to-back accepts with in_valid held high.
    seq[0] = 5'd15; seq[1] = 5'd30; seq[2] = 5'd0;
    n = 0; r = 0; c = 0;
    sum = seq[0]; in_valid = 1'b1; out_ready = 1'b1;
    while (r < 3 && c < 60) begin
      pre_ready = int'(in_ready);
      tick();
      c++;
      if (pre_ready != 0 && in_valid) begin
        acc[n] = c;
        n++;
        if (n < 3) sum = seq[n];
        else in_valid = 1'b0;
      end
      if (out_valid) begin
        chk("b2b_bcd", 32'(bcd), 32'(model(int'(seq[r]))));
        r++;
      end
    end
    chk("b2b_count", 32'(r), 32'd3);
    if (n == 3) begin
      chk("b2b_gap1", 32'(acc[1] - acc[0]), 32'd7);
      chk("b2b_gap2", 32'(acc[2] - acc[1]), 32'd7);
    end else begin
      chk("b2b_accepts", 32'(n), 32'd3);
    end
    in_valid = 1'b0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sum_bcd_converter.md
# sum_bcd_converter

Sequential binary-to-BCD converter that sits directly downstream of the 4-bit parallel adder. It accepts the adder's 5-bit sum (0..30) over a valid/ready handshake and converts it by shift-and-add-3 (double dabble), one bit per clock. It presents packed BCD digits over a second valid/ready handshake for display or further decimal logic.

## Interface
- IN_W, default 5: binary input width; matches the parallel adder sum width.
- DIGITS, default 2: number of BCD output digits; legal only when 10^DIGITS > 2^IN_W − 1.
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  sum is presented.
- in_ready  output  1  block can accept a sum; high only in IDLE.
- sum  input  IN_W  unsigned binary value from the adder.
- out_valid  output  1  bcd holds a completed result.
- out_ready  input  1  consumer accepts bcd.
- bcd  output  4*DIGITS  packed BCD, digit 0 (units) in bits [3:0].
- busy  output  1  high in SHIFT or DONE.

## Operation
- Clock and reset: one clock (clk); reset rst_n is synchronous, active-low.
- States are IDLE, SHIFT and DONE.
- IDLE: in_ready=1. When in_valid=1 at an edge, capture sum into the binary shift register, clear the BCD working register, load bit counter = IN_W, and go to SHIFT. sum is ignored outside the accept edge.
- SHIFT: each edge, first add 3 to every working digit ≥ 5, then shift the {BCD working, binary} register left by 1 and decrement the counter. After the IN_W-th shift, copy the working register to bcd and go to DONE.
- DONE: out_valid=1 and bcd is stable. When out_ready=1 at an edge, go to IDLE. in_ready=0, so no new input is accepted in this state.
- bcd is a registered output, updated only on entry to DONE. It holds the last result through IDLE and SHIFT until the next result or reset.
- Each digit of bcd is always 0..9. No pattern above 9 may appear on bcd.
- in_valid asserted during SHIFT or DONE has no effect. The upstream stage must hold sum until it sees in_ready.

## Timing
- Reset: on any edge with rst_n=0, state goes to IDLE and the working register is cleared. Outputs are then in_ready=1, out_valid=0, busy=0, bcd=0.
- Reset mid-conversion (SHIFT or DONE): the conversion is abandoned with no output and no partial bcd update. Reset values as above.
- Latency: with the accept at edge k, shifts occur at edges k+1..k+IN_W. out_valid is high from edge k+IN_W onward (5 cycles for IN_W=5).
- DONE with out_ready already high: exactly one out_valid cycle, then IDLE at the next edge.
- Minimum accept-to-accept period: IN_W+2 cycles (7 for defaults).
- Backpressure: with out_ready=0, DONE, out_valid=1 and bcd are held indefinitely.
- busy = (state != IDLE), decoded directly from the state register.

## Test plan
- Reset: hold rst_n=0 for 2 edges, then release. Required: in_ready=1, out_valid=0, busy=0, bcd=8'h00. Then drop rst_n for 1 edge during SHIFT. Required: next state IDLE, out_valid never rises, bcd stays 8'h00.
- Value sweep: with out_ready=1, convert every sum 0..30 and the full IN_W range 0..31. Required: bcd equals the decimal value, e.g. 9→8'h09, 10→8'h10, 19→8'h19, 30→8'h30, 31→8'h31. out_valid must rise exactly 5 cycles after each accept.
- Backpressure: convert 23 with out_ready=0 for 4 cycles, then 1. Required: bcd=8'h23 and out_valid=1 held stable for all 5 cycles, in_ready=0 throughout, IDLE after the out_ready edge.
- Busy-input rejection: accept 7, then change sum to 29 and keep in_valid=1 during SHIFT. Required: result 8'h07, in_ready=0 until return to IDLE, then 29 accepted and giving 8'h29.
- Back-to-back: keep in_valid=1 with sums 15, 30, 0 and out_ready=1. Required: results 8'h15, 8'h30, 8'h00 in order, accepts exactly 7 cycles apart.
